// File: rtl/mult_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_iter_pkg
//  Purpose  : Shared op-code constants for the HI/LO multiply/accumulate
//             instructions and a signedness helper used by the multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_iter_pkg;

   localparam int FUNC_W = 6;

   // SPECIAL / SPECIAL2 func codes of the HI/LO producing instructions
   localparam logic [FUNC_W-1:0] FUNC_MADD  = 6'h00;
   localparam logic [FUNC_W-1:0] FUNC_MADDU = 6'h01;
   localparam logic [FUNC_W-1:0] FUNC_MSUB  = 6'h04;
   localparam logic [FUNC_W-1:0] FUNC_MSUBU = 6'h05;
   localparam logic [FUNC_W-1:0] FUNC_MULT  = 6'h18;
   localparam logic [FUNC_W-1:0] FUNC_MULTU = 6'h19;

   // Signed arithmetic only for the three signed forms; anything else is unsigned
   function automatic logic func_is_signed(input logic [FUNC_W-1:0] func);
      return (func == FUNC_MULT) || (func == FUNC_MADD) || (func == FUNC_MSUB);
   endfunction

endpackage : mult_iter_pkg
`default_nettype wire

// File: rtl/mult_iter_step.sv
`default_nettype none
// ============================================================================
//  Module   : mult_iter_step
//  Purpose  : Combinational partial-product adder for the iterative
//             multiplier: acc' = acc + (mcand * slice) << (RADIX_BITS * k).
//  Revision : 1.0 - initial release
// ============================================================================
module mult_iter_step
   import mult_iter_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RADIX_BITS = 2,
   parameter int CNT_W      = 4
) (
   input  logic [2*WIDTH-1:0]    i_acc,
   input  logic [WIDTH-1:0]      i_mcand,
   input  logic [RADIX_BITS-1:0] i_slice,
   input  logic [CNT_W-1:0]      i_k,
   output logic [2*WIDTH-1:0]    o_acc
);

   // Shift amount needs room for (N-1)*RADIX_BITS
   localparam int c_sh_w = CNT_W + $clog2(RADIX_BITS) + 1;

   logic [2*WIDTH-1:0] w_mcand_ext;
   logic [2*WIDTH-1:0] w_slice_ext;
   logic [2*WIDTH-1:0] w_pp;
   logic [c_sh_w-1:0]  w_shamt;

   // Magnitude-only partial product; sign is fixed up after the last step
   always_comb begin
      w_mcand_ext = {{WIDTH{1'b0}}, i_mcand};
      w_slice_ext = {{(2*WIDTH-RADIX_BITS){1'b0}}, i_slice};
      w_shamt     = c_sh_w'(i_k) * c_sh_w'(RADIX_BITS);
      w_pp        = (w_mcand_ext * w_slice_ext) << w_shamt;
      o_acc       = i_acc + w_pp;
   end

endmodule : mult_iter_step
`default_nettype wire

// File: rtl/mult_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_iter
//  Purpose  : Multi-cycle WIDTHxWIDTH -> 2*WIDTH multiplier feeding the HI/LO
//             accumulate stage. Sign-magnitude iteration, RADIX_BITS per cycle,
//             fixed latency of WIDTH/RADIX_BITS + 1 cycles, flushable.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_iter
   import mult_iter_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RADIX_BITS = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_flush,
   input  logic [FUNC_W-1:0] i_instr_func,
   input  logic [WIDTH-1:0]  i_op_a,
   input  logic [WIDTH-1:0]  i_op_b,
   output logic              o_busy,
   output logic              o_valid,
   output logic [FUNC_W-1:0] o_func,
   output logic [WIDTH-1:0]  o_mult_lo,
   output logic [WIDTH-1:0]  o_mult_hi
);

   localparam int c_iters = WIDTH / RADIX_BITS;
   localparam int c_cnt_w = (c_iters > 1) ? $clog2(c_iters) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_iters - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t              state_q,    state_d;
   logic [c_cnt_w-1:0]  cnt_q,      cnt_d;
   logic [WIDTH-1:0]    mcand_q,    mcand_d;
   logic [WIDTH-1:0]    mplier_q,   mplier_d;
   logic                neg_q,      neg_d;
   logic [2*WIDTH-1:0]  acc_q,      acc_d;
   logic [FUNC_W-1:0]   func_q,     func_d;
   logic [FUNC_W-1:0]   out_func_q, out_func_d;
   logic [WIDTH-1:0]    hi_q,       hi_d;
   logic [WIDTH-1:0]    lo_q,       lo_d;
   logic                valid_q,    valid_d;
   logic                busy_q,     busy_d;

   logic                w_signed;
   logic [WIDTH-1:0]    w_abs_a;
   logic [WIDTH-1:0]    w_abs_b;
   logic [2*WIDTH-1:0]  w_step_acc;
   logic [2*WIDTH-1:0]  w_result;

   mult_iter_step #(
      .WIDTH      (WIDTH),
      .RADIX_BITS (RADIX_BITS),
      .CNT_W      (c_cnt_w)
   ) u_step (
      .i_acc   (acc_q),
      .i_mcand (mcand_q),
      .i_slice (mplier_q[RADIX_BITS-1:0]),
      .i_k     (cnt_q),
      .o_acc   (w_step_acc)
   );

   // Operand magnitudes; -2^(WIDTH-1) stays representable as an unsigned value
   always_comb begin
      w_signed = func_is_signed(i_instr_func);
      w_abs_a  = (w_signed && i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
      w_abs_b  = (w_signed && i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;
      w_result = neg_q ? -w_step_acc : w_step_acc;
   end

   // Next-state logic: IDLE -> CALC (N steps) -> FIX (valid pulse) -> IDLE
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      neg_d      = neg_q;
      acc_d      = acc_q;
      func_d     = func_q;
      out_func_d = out_func_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      valid_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               mcand_d  = w_abs_a;
               mplier_d = w_abs_b;
               neg_d    = w_signed & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
               func_d   = i_instr_func;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            acc_d    = w_step_acc;
            mplier_d = mplier_q >> RADIX_BITS;
            cnt_d    = cnt_q + c_cnt_w'(1);
            if (cnt_q == c_last) begin
               // Result registered straight off the final step so valid lands
               // in the cycle after the last iteration.
               {hi_d, lo_d} = w_result;
               out_func_d   = func_q;
               valid_d      = 1'b1;
               cnt_d        = '0;
               state_d      = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Flush aborts everything, including a same-cycle start; the delivered
      // outputs keep their last values.
      if (i_flush) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         func_d     = func_q;
         out_func_d = out_func_q;
         hi_d       = hi_q;
         lo_d       = lo_q;
         valid_d    = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         neg_q      <= 1'b0;
         acc_q      <= '0;
         func_q     <= '0;
         out_func_q <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         neg_q      <= neg_d;
         acc_q      <= acc_d;
         func_q     <= func_d;
         out_func_q <= out_func_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
      end
   end

   assign o_busy    = busy_q;
   assign o_valid   = valid_q;
   assign o_func    = out_func_q;
   assign o_mult_hi = hi_q;
   assign o_mult_lo = lo_q;

endmodule : mult_iter
`default_nettype wire

// File: tb/tb_mult_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_iter
//  Purpose  : Self-checking bench for mult_iter: directed vector table,
//             flush / ignored-start / async-reset sequences and a random
//             signed/unsigned regression against a 64-bit reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_iter;
   import mult_iter_pkg::*;

   localparam int WIDTH      = 32;
   localparam int RADIX_BITS = 2;
   localparam int N          = WIDTH / RADIX_BITS;
   localparam int LAT        = N + 1;
   localparam int NV         = 10;
   localparam int NRAND      = 300;

   typedef struct {
      logic [5:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] prod;
   } vec_t;

   typedef struct {
      logic [63:0] prod;
      logic [5:0]  func;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic        i_flush;
   logic [5:0]  i_instr_func;
   logic [31:0] i_op_a;
   logic [31:0] i_op_b;
   logic        o_busy;
   logic        o_valid;
   logic [5:0]  o_func;
   logic [31:0] o_mult_lo;
   logic [31:0] o_mult_hi;

   int          n_checks = 0;
   int          n_fail   = 0;
   sb_t         sb_q[$];
   sb_t         mon_e;
   logic [63:0] last_prod = '0;
   logic [5:0]  last_func = '0;
   vec_t        vecs[NV];
   logic [5:0]  funcs[6];

   mult_iter #(
      .WIDTH      (WIDTH),
      .RADIX_BITS (RADIX_BITS)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (i_start),
      .i_flush      (i_flush),
      .i_instr_func (i_instr_func),
      .i_op_a       (i_op_a),
      .i_op_b       (i_op_b),
      .o_busy       (o_busy),
      .o_valid      (o_valid),
      .o_func       (o_func),
      .o_mult_lo    (o_mult_lo),
      .o_mult_hi    (o_mult_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mult(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic        [63:0] ua;
      logic        [63:0] ub;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (f == FUNC_MULT || f == FUNC_MADD || f == FUNC_MSUB)
         return sa * sb;
      return ua * ub;
   endfunction

   // Scoreboard: every o_valid pulse must match the oldest outstanding op
   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: o_valid=1 with no op outstanding, expected 0");
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_product", {o_mult_hi, o_mult_lo}, mon_e.prod);
            check("sb_func", {58'd0, o_func}, {58'd0, mon_e.func});
            last_prod = mon_e.prod;
            last_func = mon_e.func;
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at the negedge after o_valid
   task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] p, input string tag);
      int lat;
      bit got;
      i_start      = 1'b1;
      i_instr_func = f;
      i_op_a       = a;
      i_op_b       = b;
      sb_q.push_back('{prod: p, func: f});
      @(negedge clk);
      i_start      = 1'b0;
      i_op_a       = $urandom;
      i_op_b       = $urandom;
      i_instr_func = 6'h3F;
      check({tag, "_busy_c1"}, {63'd0, o_busy}, 64'd1);
      lat = 1;
      got = 1'b0;
      while (lat <= 4 * LAT) begin
         if (o_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      check({tag, "_valid_seen"}, {63'd0, got}, 64'd1);
      if (got) begin
         check({tag, "_latency"}, 64'(lat), 64'(LAT));
         check({tag, "_busy_at_valid"}, {63'd0, o_busy}, 64'd1);
      end
      @(negedge clk);
      check({tag, "_valid_one_cycle"}, {63'd0, o_valid}, 64'd0);
      check({tag, "_busy_after"}, {63'd0, o_busy}, 64'd0);
      check({tag, "_prod_held"}, {o_mult_hi, o_mult_lo}, p);
      check({tag, "_func_held"}, {58'd0, o_func}, {58'd0, f});
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
      check({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
      check({tag, "_func"}, {58'd0, o_func}, 64'd0);
      check({tag, "_hi"}, {32'd0, o_mult_hi}, 64'd0);
      check({tag, "_lo"}, {32'd0, o_mult_lo}, 64'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  lat;
      bit  got;
      logic [5:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
      vecs[1] = '{FUNC_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000};
      vecs[2] = '{FUNC_MULT,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
      vecs[3] = '{FUNC_MADD,  32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE};
      vecs[4] = '{FUNC_MULTU, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
      vecs[5] = '{FUNC_MULT,  32'h00000000, 32'hDEADBEEF, 64'h00000000_00000000};
      vecs[6] = '{FUNC_MSUBU, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE};
      vecs[7] = '{FUNC_MULT,  32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
      vecs[8] = '{FUNC_MSUB,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
      vecs[9] = '{FUNC_MADDU, 32'h12345678, 32'h00000010, 64'h00000001_23456780};
      funcs   = '{FUNC_MULT, FUNC_MULTU, FUNC_MADD, FUNC_MADDU, FUNC_MSUB, FUNC_MSUBU};

      rst_n        = 1'b0;
      i_start      = 1'b0;
      i_flush      = 1'b0;
      i_instr_func = '0;
      i_op_a       = '0;
      i_op_b       = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vector table, issued back-to-back
      for (int i = 0; i < NV; i++)
         do_op(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));

      // Flush in cycle 5: no valid, busy drops in cycle 6, restart in cycle 6
      i_start      = 1'b1;
      i_instr_func = FUNC_MULTU;
      i_op_a       = 32'h0000_1234;
      i_op_b       = 32'h0000_5678;
      @(negedge clk);
      i_start = 1'b0;
      repeat (4) @(negedge clk);
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      check("flush_busy", {63'd0, o_busy}, 64'd0);
      check("flush_valid", {63'd0, o_valid}, 64'd0);
      check("flush_prod_kept", {o_mult_hi, o_mult_lo}, last_prod);
      check("flush_func_kept", {58'd0, o_func}, {58'd0, last_func});
      do_op(FUNC_MULT, 32'hFFFF_FF9C, 32'h0000_0064, 64'hFFFFFFFF_FFFFD8F0, "after_flush");

      // Start together with flush is dropped
      i_start      = 1'b1;
      i_flush      = 1'b1;
      i_instr_func = FUNC_MULTU;
      i_op_a       = 32'd3;
      i_op_b       = 32'd5;
      @(negedge clk);
      i_start = 1'b0;
      i_flush = 1'b0;
      check("start_flush_dropped", {63'd0, o_busy}, 64'd0);
      repeat (LAT + 2) @(negedge clk);

      // Start while busy is ignored (mid-CALC and during the valid cycle)
      i_start      = 1'b1;
      i_instr_func = FUNC_MULTU;
      i_op_a       = 32'd1000;
      i_op_b       = 32'd3000;
      sb_q.push_back('{prod: 64'd3000000, func: FUNC_MULTU});
      @(negedge clk);
      i_start = 1'b0;
      repeat (4) @(negedge clk);
      i_start      = 1'b1;
      i_instr_func = FUNC_MULT;
      i_op_a       = 32'hFFFF_FFFF;
      i_op_b       = 32'd9;
      @(negedge clk);
      i_start = 1'b0;
      lat = 6;
      got = 1'b0;
      while (lat <= 4 * LAT) begin
         if (o_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      check("ignore_valid_seen", {63'd0, got}, 64'd1);
      check("ignore_latency", 64'(lat), 64'(LAT));
      i_start      = 1'b1;
      i_instr_func = FUNC_MADDU;
      i_op_a       = 32'd7;
      i_op_b       = 32'd7;
      @(negedge clk);
      i_start = 1'b0;
      check("start_in_fix_ignored", {63'd0, o_busy}, 64'd0);
      do_op(FUNC_MADDU, 32'd7, 32'd7, 64'd49, "after_ignore");

      // Asynchronous reset in the middle of CALC
      i_start      = 1'b1;
      i_instr_func = FUNC_MULT;
      i_op_a       = 32'h8000_0001;
      i_op_b       = 32'h0000_0003;
      @(negedge clk);
      i_start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      last_prod = '0;
      last_func = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", {63'd0, o_busy}, 64'd0);
      do_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'h0000_0001, 64'h00000000_FFFFFFFF, "after_rst");

      // Random regression with operand corner values mixed in
      for (int i = 0; i < NRAND; i++) begin
         rf = funcs[$urandom_range(0, 5)];
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: ra = 32'h8000_0000;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h0;
            3: rb = 32'h7FFF_FFFF;
            default: ;
         endcase
         do_op(rf, ra, rb, ref_mult(rf, ra, rb), "rand");
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mult_iter
`default_nettype wire
